pico_reg_file: RTL and testbench
================================

Name: pico_reg_file

Overview:
- Register file for the pico MIPS datapath: M registers of N bits each.
- Ports: one synchronous write port and two combinational read ports.
- The write port shares its address (Rd) with the first read port.
- Register 0 is hardwired to zero. Sits between instruction decode and the ALU; Rs/Rd come from instruction fields.

Parameters:
- N, 8: register data width in bits.
- M, 32: number of registers; address width A = $clog2(M), 5 at default.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- Rd  input  A  destination address; also read address for Rd_data.
- Rs  input  A  source address for Rs_data.
- Wdata  input  N  write data.
- w_enable  input  1  write strobe, sampled at the rising edge of clk.
- Rd_data  output  N  contents of register Rd (combinational).
- Rs_data  output  N  contents of register Rs (combinational).

Behaviour:
- Storage: array regs[0..M-1] of N bits.
- Reset: reset=1 asynchronously clears all regs to 0. Rd_data and Rs_data read 0 while reset is held. Reset wins over a simultaneous write.
- Write: at posedge clk, if w_enable=1, reset=0 and Rd!=0, then regs[Rd] <= Wdata. Latency is 1 edge.
- Register 0: writes with Rd=0 are silently discarded, and register 0 always reads 0. It need not be physically stored.
- Reads: combinational, zero latency. Rd_data = regs[Rd] and Rs_data = regs[Rs].
- Out-of-range addresses (address >= M, possible only when M is not a power of 2): reads return 0, writes are ignored.
- Read-during-write, feature disabled: before the edge, outputs show the old contents. After the edge, the new value appears in the same cycle the edge occurs.
- Rs==Rd is legal; both ports return the same value.
- w_enable held high over several edges writes on every edge. The last write wins.
- There are no X propagation paths from unused registers.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through bypass on both read ports. When w_enable=1, reset=0, Rd!=0 and the read address equals Rd, that port outputs Wdata combinationally, before the edge.
- Undefined: no bypass; reads show stored contents only, as in Behaviour.

Decomposition:
- Shared package pico_pkg holds:
  - REG_ADDR_W = 5;
  - REG_DATA_W = 8;
  - NUM_REGS = 32;
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]);
  - typedef reg_data_t (logic [REG_DATA_W-1:0]);
  - ZERO_REG constant = 0.
- Sub-module reg_read_port: address plus array in, data out. It implements zero-register, range and bypass logic, and is instantiated twice (Rd port, Rs port).

Test Plan:
- Reset: assert reset mid-simulation after writing 55 to reg 5 -> Rd_data=Rs_data=0 immediately (asynchronous), and reg 5 reads 0 after reset is released.
- Zero register: Wdata=133, Rd=0, w_enable pulsed for one edge -> Rd_data=0; Rs=0 -> Rs_data=0.
- Basic writes: (Rd=22, Wdata=133), (Rd=31, Wdata=233), (Rd=1, Wdata=33), each pulsed for one edge -> Rd_data equals Wdata after each edge. Then Rs=22 -> Rs_data=133, and regs 31/1 still read 233/33.
- Enable low: Rd=22, Wdata=99, w_enable=0 over 3 edges -> Rd_data remains 133.
- Dual read / same address: Rs=Rd=31 -> both outputs 233. Rs=1, Rd=22 -> Rs_data=33, Rd_data=133.
- Bypass: Rd=Rs=7, Wdata=77, w_enable=1 before the edge -> with REG_FILE_BYPASS_EN both outputs show 77 pre-edge; without it they show 0 pre-edge and 77 post-edge.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared definitions for the pico MIPS datapath.
//
// Contents:
//   REG_ADDR_W / REG_DATA_W / NUM_REGS - default register-file geometry
//   reg_addr_t / reg_data_t            - address and data word types
//   ZERO_REG                           - index of the hardwired-zero register
package pico_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 8;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_read_port.sv
// Combinational read port for pico_reg_file.
//
// Handles the hardwired-zero register, out-of-range addresses and (optionally)
// write-through bypass. Instantiated once per read port.
//
// Configuration macro: REG_FILE_BYPASS_EN - when defined, a pending write to
// the addressed register is forwarded to the output before the clock edge.
//
// Ports:
//   reset     in  1   asynchronous reset, forces output to zero
//   addr      in  A   read address
//   regs      in  N*M register contents (entry 0 is ignored)
//   w_enable  in  1   write strobe (bypass build only)
//   Rd        in  A   write address (bypass build only)
//   Wdata     in  N   write data (bypass build only)
//   rdata     out N   read data
module reg_read_port
    import pico_pkg::*;
#(
    parameter int N = REG_DATA_W,
    parameter int M = NUM_REGS,
    localparam int A = $clog2(M)
) (
    input  logic         reset,
    input  logic [A-1:0] addr,
    input  logic [N-1:0] regs [M],
`ifdef REG_FILE_BYPASS_EN
    input  logic         w_enable,
    input  logic [A-1:0] Rd,
    input  logic [N-1:0] Wdata,
`endif
    output logic [N-1:0] rdata
);

    logic addr_valid;

    // Zero register and addresses beyond the array never carry data.
    assign addr_valid = (addr != A'(ZERO_REG)) && (int'(addr) < M);

`ifdef REG_FILE_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit = w_enable && (Rd == addr) && addr_valid;

    always_comb begin
        rdata = '0;
        if (!reset && addr_valid) begin
            if (bypass_hit) begin
                rdata = Wdata;
            end else begin
                rdata = regs[addr];
            end
        end
    end
`else
    always_comb begin
        rdata = '0;
        if (!reset && addr_valid) begin
            rdata = regs[addr];
        end
    end
`endif

endmodule

// File: rtl/pico_reg_file.sv
// Register file for the pico MIPS datapath: M registers of N bits, one
// synchronous write port sharing its address with the first of two
// combinational read ports. Register 0 reads as zero and ignores writes.
//
// Configuration macro: REG_FILE_BYPASS_EN - enables write-through bypass on
// both read ports (see reg_read_port).
//
// Ports:
//   clk       in  1  system clock, writes on rising edge
//   reset     in  1  asynchronous active-high reset, clears all registers
//   Rd        in  A  write address and Rd_data read address
//   Rs        in  A  Rs_data read address
//   Wdata     in  N  write data
//   w_enable  in  1  write strobe
//   Rd_data   out N  contents of register Rd
//   Rs_data   out N  contents of register Rs
module pico_reg_file
    import pico_pkg::*;
#(
    parameter int N = REG_DATA_W,
    parameter int M = NUM_REGS,
    localparam int A = $clog2(M)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] Rd,
    input  logic [A-1:0] Rs,
    input  logic [N-1:0] Wdata,
    input  logic         w_enable,
    output logic [N-1:0] Rd_data,
    output logic [N-1:0] Rs_data
);

    // Register 0 has no storage; the read view ties it to zero.
    logic [N-1:0] store [1:M-1];
    logic [N-1:0] regs_view [M];
    logic         wr_valid;

    assign wr_valid = w_enable && (Rd != A'(ZERO_REG)) && (int'(Rd) < M);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < M; i++) begin
                store[i] <= '0;
            end
        end else if (wr_valid) begin
            store[Rd] <= Wdata;
        end
    end

    always_comb begin
        regs_view[0] = '0;
        for (int unsigned i = 1; i < M; i++) begin
            regs_view[i] = store[i];
        end
    end

    reg_read_port #(.N(N), .M(M)) u_rd_port (
        .reset    (reset),
        .addr     (Rd),
        .regs     (regs_view),
`ifdef REG_FILE_BYPASS_EN
        .w_enable (w_enable),
        .Rd       (Rd),
        .Wdata    (Wdata),
`endif
        .rdata    (Rd_data)
    );

    reg_read_port #(.N(N), .M(M)) u_rs_port (
        .reset    (reset),
        .addr     (Rs),
        .regs     (regs_view),
`ifdef REG_FILE_BYPASS_EN
        .w_enable (w_enable),
        .Rd       (Rd),
        .Wdata    (Wdata),
`endif
        .rdata    (Rs_data)
    );

endmodule

// File: tb/tb_pico_reg_file.sv
// Directed self-checking bench for pico_reg_file (default geometry 32 x 8).
module tb_pico_reg_file;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rd;
    logic [4:0] Rs;
    logic [7:0] Wdata;
    logic       w_enable;
    logic [7:0] Rd_data;
    logic [7:0] Rs_data;

    int tests = 0;
    int fails = 0;

    pico_reg_file #(.N(8), .M(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .Rd       (Rd),
        .Rs       (Rs),
        .Wdata    (Wdata),
        .w_enable (w_enable),
        .Rd_data  (Rd_data),
        .Rs_data  (Rs_data)
    );

    always #5 clk = ~clk;

    // One-edge write pulse: drive at negedge, release 1 time unit after posedge.
    task automatic do_write(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        Rd = addr;
        Wdata = data;
        w_enable = 1'b1;
        @(posedge clk);
        #1;
        w_enable = 1'b0;
    endtask

    task automatic test_reset();
        // power-on reset
        reset = 1'b1; Rd = 5'd5; Rs = 5'd5; Wdata = '0; w_enable = 1'b0;
        #2;
        tests++;
        if (Rd_data !== 8'd0 || Rs_data !== 8'd0) begin
            fails++;
            $display("FAIL por_outputs: Rd_data=%0d Rs_data=%0d expected 0", Rd_data, Rs_data);
        end
        @(negedge clk);
        reset = 1'b0;
        // write 55 to reg 5, then assert reset mid-cycle
        do_write(5'd5, 8'd55);
        Rd = 5'd5; Rs = 5'd5;
        #1;
        tests++;
        if (Rd_data !== 8'd55) begin
            fails++;
            $display("FAIL reset_prewrite: Rd_data=%0d expected 55", Rd_data);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (Rd_data !== 8'd0 || Rs_data !== 8'd0) begin
            fails++;
            $display("FAIL reset_async: Rd_data=%0d Rs_data=%0d expected 0", Rd_data, Rs_data);
        end
        // reset wins over a simultaneous write
        @(negedge clk);
        Wdata = 8'd66; w_enable = 1'b1;
        @(posedge clk);
        #1;
        w_enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (Rd_data !== 8'd0 || Rs_data !== 8'd0) begin
            fails++;
            $display("FAIL reset_release: Rd_data=%0d Rs_data=%0d expected 0", Rd_data, Rs_data);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 8'd133);
        Rd = 5'd0; Rs = 5'd0;
        #1;
        tests++;
        if (Rd_data !== 8'd0) begin
            fails++;
            $display("FAIL zero_rd: Rd_data=%0d expected 0", Rd_data);
        end
        tests++;
        if (Rs_data !== 8'd0) begin
            fails++;
            $display("FAIL zero_rs: Rs_data=%0d expected 0", Rs_data);
        end
    endtask

    task automatic test_basic_writes();
        logic [4:0] addrs [3] = '{5'd22, 5'd31, 5'd1};
        logic [7:0] datas [3] = '{8'd133, 8'd233, 8'd33};
        for (int i = 0; i < 3; i++) begin
            do_write(addrs[i], datas[i]);
            tests++;
            if (Rd_data !== datas[i]) begin
                fails++;
                $display("FAIL write_%0d: Rd_data=%0d expected %0d", addrs[i], Rd_data, datas[i]);
            end
        end
        Rs = 5'd22;
        #1;
        tests++;
        if (Rs_data !== 8'd133) begin
            fails++;
            $display("FAIL read_rs22: Rs_data=%0d expected 133", Rs_data);
        end
        Rs = 5'd31; Rd = 5'd1;
        #1;
        tests++;
        if (Rs_data !== 8'd233 || Rd_data !== 8'd33) begin
            fails++;
            $display("FAIL read_31_1: Rs_data=%0d Rd_data=%0d expected 233 33", Rs_data, Rd_data);
        end
    endtask

    task automatic test_enable_low();
        @(negedge clk);
        Rd = 5'd22; Wdata = 8'd99; w_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (Rd_data !== 8'd133) begin
            fails++;
            $display("FAIL enable_low: Rd_data=%0d expected 133", Rd_data);
        end
    endtask

    task automatic test_dual_read();
        Rd = 5'd31; Rs = 5'd31;
        #1;
        tests++;
        if (Rd_data !== 8'd233 || Rs_data !== 8'd233) begin
            fails++;
            $display("FAIL same_addr: Rd_data=%0d Rs_data=%0d expected 233", Rd_data, Rs_data);
        end
        Rs = 5'd1; Rd = 5'd22;
        #1;
        tests++;
        if (Rs_data !== 8'd33 || Rd_data !== 8'd133) begin
            fails++;
            $display("FAIL dual_addr: Rs_data=%0d Rd_data=%0d expected 33 133", Rs_data, Rd_data);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] pre_exp;
`ifdef REG_FILE_BYPASS_EN
        pre_exp = 8'd77;
`else
        pre_exp = 8'd0;
`endif
        @(negedge clk);
        Rd = 5'd7; Rs = 5'd7; Wdata = 8'd77; w_enable = 1'b1;
        #1;
        tests++;
        if (Rd_data !== pre_exp || Rs_data !== pre_exp) begin
            fails++;
            $display("FAIL bypass_pre: Rd_data=%0d Rs_data=%0d expected %0d", Rd_data, Rs_data, pre_exp);
        end
        @(posedge clk);
        #1;
        w_enable = 1'b0;
        #1;
        tests++;
        if (Rd_data !== 8'd77 || Rs_data !== 8'd77) begin
            fails++;
            $display("FAIL bypass_post: Rd_data=%0d Rs_data=%0d expected 77", Rd_data, Rs_data);
        end
        // no forwarding to the zero register even with bypass
        @(negedge clk);
        Rd = 5'd0; Rs = 5'd0; Wdata = 8'd5; w_enable = 1'b1;
        #1;
        tests++;
        if (Rd_data !== 8'd0 || Rs_data !== 8'd0) begin
            fails++;
            $display("FAIL bypass_zero: Rd_data=%0d Rs_data=%0d expected 0", Rd_data, Rs_data);
        end
        @(posedge clk);
        #1;
        w_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3] = '{8'd10, 8'd11, 8'd12};
        @(negedge clk);
        Rd = 5'd9; Rs = 5'd9; w_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Wdata = seq[i];
            @(posedge clk);
            #1;
            tests++;
            if (Rs_data !== seq[i]) begin
                fails++;
                $display("FAIL b2b_%0d: Rs_data=%0d expected %0d", i, Rs_data, seq[i]);
            end
            @(negedge clk);
        end
        w_enable = 1'b0;
        Wdata = 8'd200;
        @(posedge clk);
        #1;
        tests++;
        if (Rd_data !== 8'd12) begin
            fails++;
            $display("FAIL b2b_last: Rd_data=%0d expected 12", Rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_basic_writes();
        test_enable_low();
        test_dual_read();
        test_bypass();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
